// File: rtl/game_pkg.sv
// Shared encodings for the player input sequencer.
//   game_state_e   : TITLE/PLAY/PAUSE/OVER top-level game states
//   dir_e          : movement / facing directions
//   FACING_DEFAULT : facing after reset
//   BTN_*          : bit positions of the buttons in the packed raw-button vector
package game_pkg;

  typedef enum logic [1:0] {
    TITLE = 2'b00,
    PLAY  = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } game_state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam dir_e FACING_DEFAULT = DIR_DOWN;

  localparam int unsigned NUM_BTN   = 8;
  localparam int unsigned BTN_A     = 0;
  localparam int unsigned BTN_B     = 1;
  localparam int unsigned BTN_SEL   = 2;
  localparam int unsigned BTN_START = 3;
  localparam int unsigned BTN_UP    = 4;
  localparam int unsigned BTN_DOWN  = 5;
  localparam int unsigned BTN_LEFT  = 6;
  localparam int unsigned BTN_RIGHT = 7;

endpackage

// File: rtl/player_input_sequencer_if.sv
// Pad-side and player-side signals of the player input sequencer.
//   master : drives frame_tick, buttons and player_health; observes the sequencer outputs
//   slave  : the sequencer itself
interface player_input_sequencer_if;
  import game_pkg::*;

  logic        frame_tick;
  logic        A;
  logic        B;
  logic        select;
  logic        start;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic [1:0]  player_health;

  game_state_e game_state;
  logic        move_en;
  dir_e        move_dir;
  dir_e        facing;
  logic        attack_active;
  logic        player_reset;

  modport master (
    output frame_tick, A, B, select, start, up, down, left, right, player_health,
    input  game_state, move_en, move_dir, facing, attack_active, player_reset
  );

  modport slave (
    input  frame_tick, A, B, select, start, up, down, left, right, player_health,
    output game_state, move_en, move_dir, facing, attack_active, player_reset
  );

endinterface

// File: rtl/button_frame_latch.sv
// Sticky per-frame latch for one raw button.
//   clk, reset : clock, asynchronous active-high reset
//   frame_tick : one-cycle frame pulse; clears the latch
//   raw        : raw active-high button
//   sample     : latch | raw, the value the current frame sees
//   rise       : sample high while the previous frame's sample was low
module button_frame_latch (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic raw,
  output logic sample,
  output logic rise
);

  logic latch_q, latch_d;
  logic prev_q, prev_d;

  // A press in the tick cycle itself still counts for the frame being closed.
  assign sample = latch_q | raw;
  assign rise   = sample & ~prev_q;

  always_comb begin
    latch_d = frame_tick ? 1'b0 : sample;
    prev_d  = frame_tick ? sample : prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      latch_q <= latch_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/player_input_sequencer.sv
// Frame-rate controller for the player block: latches pad buttons between frame ticks,
// resolves direction conflicts, paces movement, times attacks with a cooldown and runs
// the TITLE/PLAY/PAUSE/OVER game state machine. Every decision is taken in the
// frame_tick cycle; outputs are registered and valid the cycle after.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pad inputs, player_health, and all sequencer outputs (slave side)
module player_input_sequencer
  import game_pkg::*;
#(
  parameter int unsigned MOVE_DIV        = 2,
  parameter int unsigned ATTACK_FRAMES   = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  player_input_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] MoveWrap = CNT_W'(MOVE_DIV - 1);
  localparam logic [CNT_W-1:0] AtkLoad  = CNT_W'(ATTACK_FRAMES - 1);
  // The frame on which the attack ends already counts as the first cooldown frame.
  localparam logic [CNT_W-1:0] CdLoad   =
      (COOLDOWN_FRAMES == 0) ? '0 : CNT_W'(COOLDOWN_FRAMES - 1);

  logic tick;
  assign tick = bus.frame_tick;

  // Button latches
  logic [NUM_BTN-1:0] raw, sample, rise;
  assign raw = {bus.right, bus.left, bus.down, bus.up, bus.start, bus.select, bus.B, bus.A};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_frame_latch u_latch (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (tick),
      .raw        (raw[i]),
      .sample     (sample[i]),
      .rise       (rise[i])
    );
  end

  logic unused_rise;
  assign unused_rise = ^{rise[BTN_RIGHT], rise[BTN_LEFT], rise[BTN_DOWN], rise[BTN_UP],
                         rise[BTN_B], rise[BTN_A]};

  // Direction resolve: opposing pairs cancel, vertical beats horizontal.
  logic v_up, v_down, h_left, h_right, dir_valid;
  dir_e dir_res;

  always_comb begin
    v_up      = sample[BTN_UP] & ~sample[BTN_DOWN];
    v_down    = sample[BTN_DOWN] & ~sample[BTN_UP];
    h_right   = sample[BTN_RIGHT] & ~sample[BTN_LEFT];
    h_left    = sample[BTN_LEFT] & ~sample[BTN_RIGHT];
    dir_valid = v_up | v_down | h_right | h_left;
    if (v_up)         dir_res = DIR_UP;
    else if (v_down)  dir_res = DIR_DOWN;
    else if (h_right) dir_res = DIR_RIGHT;
    else              dir_res = DIR_LEFT;
  end

  // Game state machine
  game_state_e state_q, state_d;
  logic        player_reset_q, player_reset_d;

  always_comb begin
    state_d        = state_q;
    player_reset_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        TITLE: begin
          if (rise[BTN_START]) begin
            state_d        = PLAY;
            player_reset_d = 1'b1;
          end
        end
        PLAY: begin
          if (bus.player_health == 2'd0) state_d = OVER;
          else if (rise[BTN_START])      state_d = PAUSE;
        end
        PAUSE: begin
          if (rise[BTN_SEL])        state_d = TITLE;
          else if (rise[BTN_START]) state_d = PLAY;
        end
        OVER: begin
          if (rise[BTN_START]) state_d = TITLE;
        end
        default: state_d = TITLE;
      endcase
    end
  end

  // Movement and attack
  logic             move_en_q, move_en_d;
  dir_e             move_dir_q, move_dir_d;
  dir_e             facing_q, facing_d;
  logic             attack_q, attack_d;
  logic [CNT_W-1:0] atk_cnt_q, atk_cnt_d;
  logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
  logic [CNT_W-1:0] move_cnt_q, move_cnt_d;

  logic play_frame, atk_ending, atk_busy, cd_blocks, atk_start, move_wrap;

  // Only frames that start and stay in PLAY act; the entry/exit ticks do not.
  assign play_frame = tick && (state_q == PLAY) && (state_d == PLAY);
  assign atk_ending = attack_q && (atk_cnt_q == '0);
  assign atk_busy   = attack_q && !atk_ending;
  assign cd_blocks  = atk_ending ? (COOLDOWN_FRAMES != 0) : (cd_cnt_q != '0);
  assign atk_start  = play_frame && (sample[BTN_A] | sample[BTN_B]) && !atk_busy && !cd_blocks;
  assign move_wrap  = (move_cnt_q == MoveWrap);

  always_comb begin
    move_en_d  = 1'b0;
    move_dir_d = move_dir_q;
    facing_d   = facing_q;
    attack_d   = attack_q;
    atk_cnt_d  = atk_cnt_q;
    cd_cnt_d   = cd_cnt_q;
    move_cnt_d = move_cnt_q;

    if (tick && !play_frame) begin
      attack_d  = 1'b0;
      atk_cnt_d = '0;
      cd_cnt_d  = '0;
    end else if (play_frame) begin
      if (atk_start) begin
        attack_d  = 1'b1;
        atk_cnt_d = AtkLoad;
        cd_cnt_d  = '0;
      end else if (atk_busy) begin
        atk_cnt_d = atk_cnt_q - 1'b1;
      end else if (atk_ending) begin
        attack_d = 1'b0;
        cd_cnt_d = CdLoad;
      end else if (cd_cnt_q != '0) begin
        cd_cnt_d = cd_cnt_q - 1'b1;
      end

      // attack_q still covers the frame the attack ends, so movement resumes one later.
      if (dir_valid && (!attack_q || atk_start)) facing_d = dir_res;

      if (!attack_q && !atk_start) begin
        move_cnt_d = move_wrap ? '0 : move_cnt_q + 1'b1;
        if (move_wrap && dir_valid) begin
          move_en_d  = 1'b1;
          move_dir_d = dir_res;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= TITLE;
      player_reset_q <= 1'b0;
      move_en_q      <= 1'b0;
      move_dir_q     <= DIR_UP;
      facing_q       <= FACING_DEFAULT;
      attack_q       <= 1'b0;
      atk_cnt_q      <= '0;
      cd_cnt_q       <= '0;
      move_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      player_reset_q <= player_reset_d;
      move_en_q      <= move_en_d;
      move_dir_q     <= move_dir_d;
      facing_q       <= facing_d;
      attack_q       <= attack_d;
      atk_cnt_q      <= atk_cnt_d;
      cd_cnt_q       <= cd_cnt_d;
      move_cnt_q     <= move_cnt_d;
    end
  end

  assign bus.game_state    = state_q;
  assign bus.move_en       = move_en_q;
  assign bus.move_dir      = move_dir_q;
  assign bus.facing        = facing_q;
  assign bus.attack_active = attack_q;
  assign bus.player_reset  = player_reset_q;

endmodule

// File: tb/tb_player_input_sequencer.sv
// Bench for player_input_sequencer: directed frames, a frame-level reference model
// compared on every falling edge, and hand-computed spot checks.
module tb_player_input_sequencer;

  localparam int MD  = 2;
  localparam int ATK = 4;
  localparam int CD  = 8;

  localparam int IA = 0, IB = 1, ISEL = 2, IST = 3, IUP = 4, IDN = 5, ILF = 6, IRT = 7;
  localparam logic [7:0] K_NONE = 8'h00, K_A = 8'h01, K_SEL = 8'h04, K_ST = 8'h08;
  localparam logic [7:0] K_UP = 8'h10, K_DN = 8'h20, K_LF = 8'h40, K_RT = 8'h80;

  logic       clk;
  logic       reset;
  logic [7:0] raw_vec;
  logic       chk_en;
  int         tests;
  int         fails;

  player_input_sequencer_if bus ();

  assign bus.A      = raw_vec[IA];
  assign bus.B      = raw_vec[IB];
  assign bus.select = raw_vec[ISEL];
  assign bus.start  = raw_vec[IST];
  assign bus.up     = raw_vec[IUP];
  assign bus.down   = raw_vec[IDN];
  assign bus.left   = raw_vec[ILF];
  assign bus.right  = raw_vec[IRT];

  player_input_sequencer #(
    .MOVE_DIV        (MD),
    .ATTACK_FRAMES   (ATK),
    .COOLDOWN_FRAMES (CD),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: frame numbers and "earliest allowed attack frame" arithmetic.
  logic [7:0] m_pend, m_prev;
  int         m_mode, m_fr, m_phase, m_atk_f, m_next_ok;
  logic [1:0] exp_state, exp_move_dir, exp_facing;
  logic       exp_move_en, exp_attack, exp_prst;

  always @(posedge clk or posedge reset) begin : model
    logic [7:0] smp;
    int         vert, horiz, dir, nmode, fr_n;
    logic       st_rise, sel_rise, busy, can_go;
    if (reset) begin
      m_pend <= '0; m_prev <= '0; m_mode <= 0; m_fr <= 0; m_phase <= 0;
      m_atk_f <= -1; m_next_ok <= 0;
      exp_state <= 2'd0; exp_move_en <= 1'b0; exp_move_dir <= 2'd0;
      exp_facing <= 2'd2; exp_attack <= 1'b0; exp_prst <= 1'b0;
    end else begin
      smp = m_pend | raw_vec;
      exp_move_en <= 1'b0;
      exp_prst    <= 1'b0;
      if (!bus.frame_tick) begin
        m_pend <= smp;
      end else begin
        m_pend <= '0;
        m_prev <= smp;
        fr_n = m_fr + 1;
        m_fr <= fr_n;
        st_rise  = smp[IST] && !m_prev[IST];
        sel_rise = smp[ISEL] && !m_prev[ISEL];
        vert  = int'(smp[IDN]) - int'(smp[IUP]);
        horiz = int'(smp[IRT]) - int'(smp[ILF]);
        dir = (vert < 0) ? 0 : (vert > 0) ? 2 : (horiz > 0) ? 1 : (horiz < 0) ? 3 : -1;
        nmode = m_mode;
        case (m_mode)
          0: if (st_rise) nmode = 1;
          1: if (bus.player_health == 2'd0) nmode = 3; else if (st_rise) nmode = 2;
          2: if (sel_rise) nmode = 0; else if (st_rise) nmode = 1;
          default: if (st_rise) nmode = 0;
        endcase
        m_mode    <= nmode;
        exp_state <= 2'(nmode);
        exp_prst  <= (m_mode == 0) && (nmode == 1);
        if (!(m_mode == 1 && nmode == 1)) begin
          m_atk_f <= -1; m_next_ok <= 0; exp_attack <= 1'b0;
        end else begin
          busy   = (m_atk_f >= 0) && (fr_n <= m_atk_f + ATK);
          can_go = (smp[IA] || smp[IB]) && (m_atk_f < 0 || fr_n >= m_atk_f + ATK)
                   && (fr_n >= m_next_ok);
          if (can_go) begin
            m_atk_f    <= fr_n;
            m_next_ok  <= fr_n + ATK + CD;
            exp_attack <= 1'b1;
            if (dir >= 0) exp_facing <= 2'(dir);
          end else begin
            exp_attack <= (m_atk_f >= 0) && (fr_n < m_atk_f + ATK);
            if (!busy) begin
              m_phase <= m_phase + 1;
              if (dir >= 0) exp_facing <= 2'(dir);
              if (dir >= 0 && (m_phase % MD) == MD - 1) begin
                exp_move_en  <= 1'b1;
                exp_move_dir <= 2'(dir);
              end
            end
          end
        end
      end
    end
  end

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        tests++;
        if ({bus.game_state, bus.move_en, bus.move_dir, bus.facing, bus.attack_active,
             bus.player_reset} !==
            {exp_state, exp_move_en, exp_move_dir, exp_facing, exp_attack, exp_prst}) begin
          fails++;
          $display("FAIL cycle t=%0t: dut st=%0d men=%0d mdir=%0d face=%0d atk=%0d prst=%0d; model st=%0d men=%0d mdir=%0d face=%0d atk=%0d prst=%0d",
                   $time, bus.game_state, bus.move_en, bus.move_dir, bus.facing,
                   bus.attack_active, bus.player_reset, exp_state, exp_move_en,
                   exp_move_dir, exp_facing, exp_attack, exp_prst);
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: three quiet cycles then the tick cycle; pulse is added in cycle 1 only.
  task automatic frame(input logic [7:0] hold, input logic [7:0] pulse);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      raw_vec        = hold | ((c == 1) ? pulse : K_NONE);
      bus.frame_tick = (c == 3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    raw_vec        = K_NONE;
    bus.frame_tick = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; chk_en = 1'b0;
    reset = 1'b0; raw_vec = K_NONE; bus.frame_tick = 1'b0; bus.player_health = 2'd3;
    fork
      compare_loop();
    join_none
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", int'(bus.game_state), 0);
    check("reset_facing", int'(bus.facing), 2);
    check("reset_move_dir", int'(bus.move_dir), 0);
    check("reset_attack", int'(bus.attack_active), 0);
    check("reset_move_en", int'(bus.move_en), 0);

    frame(K_ST, K_NONE);                                   // 1: TITLE -> PLAY
    check("title_to_play", int'(bus.game_state), 1);
    check("player_reset_pulse", int'(bus.player_reset), 1);
    check("facing_after_start", int'(bus.facing), 2);
    idle_cycle();
    check("player_reset_one_cycle", int'(bus.player_reset), 0);

    for (int f = 0; f < 4; f++) begin                      // 2..5: right held
      frame(K_RT, K_NONE);
      check("right_move_en", int'(bus.move_en), (f % 2 == 1) ? 1 : 0);
    end
    check("right_move_dir", int'(bus.move_dir), 1);
    check("right_facing", int'(bus.facing), 1);

    frame(K_UP | K_DN | K_LF, K_NONE);                     // 6
    frame(K_UP | K_DN | K_LF, K_NONE);                     // 7: step left
    check("vert_cancel_move_en", int'(bus.move_en), 1);
    check("vert_cancel_dir", int'(bus.move_dir), 3);
    frame(K_UP | K_DN, K_NONE);                            // 8
    frame(K_UP | K_DN, K_NONE);                            // 9: wrap frame, nothing resolved
    check("updown_no_move", int'(bus.move_en), 0);
    check("updown_facing_kept", int'(bus.facing), 3);

    for (int f = 0; f < 5; f++) begin                      // 10: A pulse, 11..14 quiet
      frame(K_NONE, (f == 0) ? K_A : K_NONE);
      check("attack_len", int'(bus.attack_active), (f < 4) ? 1 : 0);
    end

    for (int f = 15; f <= 21; f++) frame(K_A | K_RT, K_NONE);
    check("cooldown_blocks", int'(bus.attack_active), 0);
    frame(K_A | K_RT, K_NONE);                             // 22 = 10 + 4 + 8
    check("second_attack", int'(bus.attack_active), 1);
    check("attack_no_move", int'(bus.move_en), 0);
    for (int f = 23; f <= 25; f++) frame(K_A | K_RT, K_NONE);
    check("second_attack_held", int'(bus.attack_active), 1);
    frame(K_A | K_RT, K_NONE);                             // 26
    check("second_attack_end", int'(bus.attack_active), 0);
    frame(K_A | K_RT, K_NONE);                             // 27: movement resumes
    check("move_resumes", int'(bus.move_en), 1);

    frame(K_ST | K_RT, K_NONE);                            // 28: PLAY -> PAUSE
    check("pause_state", int'(bus.game_state), 2);
    check("pause_no_move", int'(bus.move_en), 0);
    frame(K_RT, K_NONE);                                   // 29
    check("pause_hold_no_move", int'(bus.move_en), 0);
    frame(K_ST | K_SEL, K_NONE);                           // 30: both -> TITLE
    check("pause_to_title", int'(bus.game_state), 0);

    frame(K_NONE, K_NONE);
    frame(K_ST, K_NONE);
    check("replay", int'(bus.game_state), 1);
    frame(K_NONE, K_NONE);
    bus.player_health = 2'd0;
    frame(K_ST, K_NONE);                                   // health wins over start
    check("health_over", int'(bus.game_state), 3);
    bus.player_health = 2'd3;
    frame(K_NONE, K_NONE);
    frame(K_ST, K_NONE);
    check("over_to_title", int'(bus.game_state), 0);
    frame(K_NONE, K_NONE);
    frame(K_ST, K_NONE);
    frame(K_NONE, K_NONE);
    frame(K_NONE, K_A);
    check("attack_before_reset", int'(bus.attack_active), 1);

    #1 reset = 1'b1;                                       // mid-cycle, no clock edge
    #1;
    check("async_reset_attack", int'(bus.attack_active), 0);
    check("async_reset_state", int'(bus.game_state), 0);
    check("async_reset_facing", int'(bus.facing), 2);
    @(negedge clk);
    raw_vec = K_NONE; bus.frame_tick = 1'b0; reset = 1'b0;
    idle_cycle();
    frame(K_RT, K_NONE);
    check("title_after_reset", int'(bus.game_state), 0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
